serial_frame_rx: RTL

Downstream consumer of the 8-bit shift register's shiftout serial stream. It detects a start bit, deserializes DATA_WIDTH data bits MSB-first, and optionally checks a parity bit. It then checks the stop bit and presents the recovered word with a one-cycle valid strobe plus error flags. Bit timing comes from an external enable strobe (same en that clocks the upstream shifter), so the upstream and this block stay bit-aligned.

---
 rtl/serial_frame_rx.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: strobe-timed serial frame receiver.
// Frame on the line: start(0), DATA_WIDTH data bits MSB-first, optional
// parity bit, stop(1). A bit is consumed only on clock edges where en=1,
// so the receiver stays bit-aligned with the upstream shifter sharing en.
// Each completed frame updates data_out and the error flags and raises
// data_valid for one clock.
module serial_frame_rx #(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  sclr,
  input  logic                  en,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0]   shreg, shreg_nxt;
  logic                    par_acc, par_acc_nxt;   // running XOR of data bits
  logic                    par_mis, par_mis_nxt;   // parity mismatch of current frame
  logic [DATA_WIDTH-1:0]   data_out_nxt;
  logic                    parity_err_nxt;
  logic                    frame_err_nxt;
  logic                    data_valid_nxt;

  // Next-state and datapath decode; everything holds unless en qualifies the edge.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    par_acc_nxt    = par_acc;
    par_mis_nxt    = par_mis;
    data_out_nxt   = data_out;
    parity_err_nxt = parity_err;
    frame_err_nxt  = frame_err;
    data_valid_nxt = 1'b0;      // one-clock pulse, independent of en

    if (en) begin
      unique case (state)
        S_IDLE: begin
          if (!serial_in) begin
            state_nxt   = S_DATA;
            bit_cnt_nxt = '0;
            par_acc_nxt = 1'b0;
            par_mis_nxt = 1'b0;
          end
        end

        S_DATA: begin
          shreg_nxt   = {shreg[DATA_WIDTH-2:0], serial_in};
          par_acc_nxt = par_acc ^ serial_in;
          bit_cnt_nxt = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            state_nxt   = PARITY_EN ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: begin
          // Total ones over data+parity must have the configured polarity.
          par_mis_nxt = ((par_acc ^ serial_in) != PARITY_ODD);
          state_nxt   = S_STOP;
        end

        S_STOP: begin
          data_out_nxt   = shreg;
          frame_err_nxt  = ~serial_in;
          parity_err_nxt = PARITY_EN & par_mis;
          data_valid_nxt = 1'b1;
          state_nxt      = S_IDLE;
        end

        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // State register with busy registered alongside it.
  always_ff @(posedge clk or posedge aclr) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (aclr) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else if (sclr) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  // Datapath and output registers; clears win over the bit strobe.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_mis    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (sclr) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_mis    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      par_acc    <= par_acc_nxt;
      par_mis    <= par_mis_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

endmodule
